// File: rtl/stopwatch_lap_core_if.sv
// Button inputs and display/status outputs of stopwatch_lap_core.
// The master side is the board or bench; the slave side is the core.
interface stopwatch_lap_core_if #(
    parameter int DIGITS = 4
);
    logic              sw_0;
    logic              sw_1;
    logic [DIGITS-1:0] com;
    logic [7:0]        seg_data;
    logic              led;
    logic              ovf;

    modport master (
        output sw_0, sw_1,
        input  com, seg_data, led, ovf
    );

    modport slave (
        input  sw_0, sw_1,
        output com, seg_data, led, ovf
    );
endinterface

// File: rtl/stopwatch_lap_core.sv
// Stopwatch core: debounced start/stop and lap/clear buttons, BCD counter, lap freeze, 7-seg scan.
// Optional STOPWATCH_OVF_BLINK_EN: blank the display in alternating half-second periods while ovf is set.
module stopwatch_lap_core #(
    parameter int CLK_HZ      = 32000000,
    parameter int TICK_HZ     = 100,
    parameter int DIGITS      = 4,
    parameter int DEB_CYCLES  = 320000,
    parameter int SCAN_CYCLES = 8000
) (
    input logic                 clk,
    input logic                 rst,
    stopwatch_lap_core_if.slave bus
);

    localparam int PRESC_MAX = CLK_HZ / TICK_HZ - 1;
    localparam int PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam int DEB_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int SCAN_W    = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int IDX_W     = $clog2(DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAP,
        STOP
    } state_t;

    state_t state, state_nx;

    logic [1:0]               raw;
    logic [1:0]               press;
    logic                     ev_s, ev_l;
    logic                     lap_load, clear;
    logic                     counting, tick, wrap;
    logic [PRESC_W-1:0]       presc;
    logic [DIGITS-1:0][3:0]   cnt, cnt_inc, lap, disp;
    logic [SCAN_W-1:0]        scan_cnt;
    logic [IDX_W-1:0]         idx;
    logic [3:0]               cur_digit;
    logic [DIGITS-1:0]        com_nx, com_q;
    logic [7:0]               seg_nx, seg_q;
    logic                     led_q, ovf_q;
    logic                     blank;

    function automatic logic [3:0] dig_max(input int unsigned pos);
        return (pos == 3) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Buttons idle high, so synchroniser and accepted level reset to 1.
    assign raw = {bus.sw_1, bus.sw_0};

    for (genvar b = 0; b < 2; b++) begin : g_deb
        logic             s1, s2, lvl, lvl_q;
        logic [DEB_W-1:0] dcnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1    <= 1'b1;
                s2    <= 1'b1;
                lvl   <= 1'b1;
                lvl_q <= 1'b1;
                dcnt  <= '0;
            end else begin
                s1    <= raw[b];
                s2    <= s1;
                lvl_q <= lvl;
                if (s2 == lvl) begin
                    dcnt <= '0;
                end else if (dcnt == DEB_W'(DEB_CYCLES - 1)) begin
                    lvl  <= s2;
                    dcnt <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end

        assign press[b] = lvl_q & ~lvl;
    end

    assign ev_s = press[0];
    assign ev_l = press[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Start/stop is tested first in every state so it wins over a simultaneous lap/clear.
    always_comb begin
        state_nx = state;
        lap_load = 1'b0;
        clear    = 1'b0;
        case (state)
            IDLE: if (ev_s) state_nx = RUN;
            RUN: begin
                if (ev_s) begin
                    state_nx = STOP;
                end else if (ev_l) begin
                    state_nx = LAP;
                    lap_load = 1'b1;
                end
            end
            LAP: begin
                if (ev_s)      state_nx = STOP;
                else if (ev_l) state_nx = RUN;
            end
            STOP: begin
                if (ev_s) begin
                    state_nx = RUN;
                end else if (ev_l) begin
                    state_nx = IDLE;
                    clear    = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == PRESC_W'(PRESC_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (clear || state == IDLE) begin
            presc <= '0;
        end else if (counting) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // Ripple-carry increment; a carry out of the top digit is the overflow.
    always_comb begin
        logic c;
        c       = tick;
        cnt_inc = cnt;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (cnt[i] == dig_max(i)) begin
                    cnt_inc[i] = 4'd0;
                end else begin
                    cnt_inc[i] = cnt[i] + 4'd1;
                    c          = 1'b0;
                end
            end
        end
        wrap = c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            lap   <= '0;
            ovf_q <= 1'b0;
        end else if (clear) begin
            cnt   <= '0;
            lap   <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt <= cnt_inc;
            if (lap_load) lap   <= cnt;
            if (wrap)     ovf_q <= 1'b1;
        end
    end

    assign disp = (state == LAP) ? lap : cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_CYCLES - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef STOPWATCH_OVF_BLINK_EN
    localparam int HALF  = (TICK_HZ / 2 > 0) ? TICK_HZ / 2 : 1;
    localparam int BLK_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [PRESC_W-1:0] fpresc;
    logic [BLK_W-1:0]   blk_cnt;
    logic               blk_phase;

    // Free-running timebase, independent of the count prescaler so blinking continues in STOP/IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpresc    <= '0;
            blk_cnt   <= '0;
            blk_phase <= 1'b0;
        end else if (!ovf_q) begin
            fpresc    <= '0;
            blk_cnt   <= '0;
            blk_phase <= 1'b0;
        end else if (fpresc == PRESC_W'(PRESC_MAX)) begin
            fpresc <= '0;
            if (blk_cnt == BLK_W'(HALF - 1)) begin
                blk_cnt   <= '0;
                blk_phase <= ~blk_phase;
            end else begin
                blk_cnt <= blk_cnt + 1'b1;
            end
        end else begin
            fpresc <= fpresc + 1'b1;
        end
    end

    assign blank = ovf_q & ~blk_phase;
`else
    assign blank = 1'b0;
`endif

    assign cur_digit = disp[idx];

    always_comb begin
        com_nx      = '1;
        com_nx[idx] = 1'b0;
        if (blank) com_nx = '1;
    end

    assign seg_nx = {idx == IDX_W'(2), seg7(cur_digit)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            com_q <= '1;
            seg_q <= '0;
            led_q <= 1'b0;
        end else begin
            com_q <= com_nx;
            seg_q <= seg_nx;
            led_q <= (state_nx == RUN) || (state_nx == LAP);
        end
    end

    assign bus.com      = com_q;
    assign bus.seg_data = seg_q;
    assign bus.led      = led_q;
    assign bus.ovf      = ovf_q;

endmodule
